rmgmt_mac_execute: RTL

- Execute-stage half of a RISC-MGMT multiply-accumulate extension.
- Consumes the decode_execute_t record from the extension's decode stage and runs a multi-cycle shift-add multiply.
- Stalls the core pipeline through busy.
- Produces a register writeback and the execute_memory_t record for the memory stage.
- Holds a private 32-bit accumulator.

---
 rtl/mac_ext_pkg.sv | 19 +
 rtl/mac_shift_add_core.sv | 54 +++++
 rtl/rmgmt_mac_execute.sv | 89 ++++++++
 3 files changed

// File: rtl/mac_ext_pkg.sv
// mac_ext_pkg: shared types for the RISC-MGMT multiply-accumulate extension
package mac_ext_pkg;
    localparam int MAC_XLEN = 32;
    typedef enum logic [1:0] {MUL = 2'd0, MAC = 2'd1, CLRACC = 2'd2} mac_op_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mac_state_t;
    typedef struct packed {
        logic                start;
        logic [1:0]          op;
        logic [MAC_XLEN-1:0] rs1_data;
        logic [MAC_XLEN-1:0] rs2_data;
    } decode_execute_t;
    typedef struct packed {
        logic                valid;
        logic [MAC_XLEN-1:0] result;
    } execute_memory_t;
    function automatic logic op_is_mul(input logic [1:0] op);
        return op == MUL || op == MAC;
    endfunction
endpackage

// File: rtl/mac_shift_add_core.sv
// mac_shift_add_core: iterative shift-add multiplier datapath, one multiplier bit per step
module mac_shift_add_core #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] multiplicand_in,
    input  logic [XLEN-1:0] multiplier_in,
    output logic [XLEN-1:0] product_next,
    output logic            done
);
    logic [XLEN-1:0]  mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign product_next = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign done = (mplier_q[XLEN-1:1] == '0) || (cnt_q == CNT_W'(XLEN-1));

    // load a fresh operand pair or advance one shift-add iteration
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        if (load) begin
            mcand_d  = multiplicand_in;
            mplier_d = multiplier_in;
            prod_d   = '0;
            cnt_d    = '0;
        end else if (step) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            prod_d   = product_next;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    // datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/rmgmt_mac_execute.sv
// rmgmt_mac_execute: execute stage of the MAC extension, sequencing multiply, accumulate and writeback
module rmgmt_mac_execute
    import mac_ext_pkg::*;
#(
    parameter int XLEN  = MAC_XLEN,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            CLK,
    input  logic            RST,
    input  decode_execute_t de_t,
    input  logic            flush,
    output logic            busy,
    output logic            reg_w,
    output logic [XLEN-1:0] reg_wdata,
    output logic            exception,
    output execute_memory_t em_t
);
    mac_state_t      state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] acc_q, acc_d, res_q, res_d, prod_next;
    logic            w_q, w_d, exc_q, exc_d, core_done;

    mac_shift_add_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_core (
        .clk             (CLK),
        .rst             (RST),
        .load            (state_q == IDLE && de_t.start && !flush && op_is_mul(de_t.op)),
        .step            (state_q == RUN && !flush),
        .multiplicand_in (de_t.rs1_data),
        .multiplier_in   (de_t.rs2_data),
        .product_next    (prod_next),
        .done            (core_done)
    );

    assign busy       = state_q == RUN || (state_q == IDLE && de_t.start && !flush);
    assign reg_w      = w_q && !flush;
    assign exception  = exc_q && !flush;
    assign reg_wdata  = res_q;
    assign em_t.valid = w_q && !flush;
    assign em_t.result = res_q;

    // the result is prepared on entry to DONE; acc commits on the DONE edge unless flushed
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        res_d   = res_q;
        w_d     = 1'b0;
        exc_d   = 1'b0;
        if (flush) state_d = IDLE;
        else case (state_q)
            IDLE: if (de_t.start) begin
                op_d    = de_t.op;
                state_d = op_is_mul(de_t.op) ? RUN : DONE;
                w_d     = de_t.op == CLRACC;
                exc_d   = de_t.op == 2'd3;
                res_d   = de_t.op == CLRACC ? acc_q : res_q;
            end
            RUN: if (core_done) begin
                state_d = DONE;
                w_d     = 1'b1;
                res_d   = op_q == MAC ? acc_q + prod_next : prod_next;
            end
            DONE: begin
                state_d = IDLE;
                acc_d   = op_q == MAC ? res_q : op_q == CLRACC ? '0 : acc_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, accumulator and registered output pulses
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            op_q    <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            w_q     <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            w_q     <= w_d;
            exc_q   <= exc_d;
        end
    end
endmodule
